// File: rtl/obi_rr_arbiter.sv
// obi_rr_arbiter: N-to-1 OBI arbiter that shares one subordinate port
// among NumReq managers.
//
// Address phase: the arbiter picks one requester (round-robin, or fixed
// priority when OBI_RR_ARBITER_FIXED_PRIO_EN is defined) and forwards its
// request with no added latency. If the subordinate stalls, the pick is
// locked so that the address-phase fields stay stable until the grant.
// Response phase: each accepted transaction pushes the issuing requester's
// index into an in-order ID FIFO. Every mgr_rvalid_i pops the head and
// raises sbr_rvalid_o for that requester.
//
// Handshake semantics (OBI): an address-phase transfer happens in a cycle
// where req and gnt are both high. Once req is high it must be held, with
// the fields stable, until gnt. A response is a single-cycle rvalid pulse
// and is never back-pressured.
//
// Optional build macro:
//   OBI_RR_ARBITER_FIXED_PRIO_EN - lowest index wins; no rr pointer.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   sbr_req_i/gnt_o            per-requester request / grant
//   sbr_addr_i/we_i/be_i/wdata_i  packed per-requester fields (slice i)
//   sbr_rvalid_o               per-requester response valid
//   sbr_rdata_o, sbr_err_o     broadcast response data / error
//   mgr_req_o/gnt_i            request / grant to the shared subordinate
//   mgr_addr_o/we_o/be_o/wdata_o  muxed address-phase fields
//   mgr_rvalid_i/rdata_i/err_i response from the subordinate
module obi_rr_arbiter #(
    parameter int unsigned NumReq    = 2,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned MaxTrans  = 2
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumReq-1:0]               sbr_req_i,
    output logic [NumReq-1:0]               sbr_gnt_o,
    input  logic [NumReq*AddrWidth-1:0]     sbr_addr_i,
    input  logic [NumReq-1:0]               sbr_we_i,
    input  logic [NumReq*DataWidth/8-1:0]   sbr_be_i,
    input  logic [NumReq*DataWidth-1:0]     sbr_wdata_i,
    output logic [NumReq-1:0]               sbr_rvalid_o,
    output logic [DataWidth-1:0]            sbr_rdata_o,
    output logic                            sbr_err_o,
    output logic                            mgr_req_o,
    input  logic                            mgr_gnt_i,
    output logic [AddrWidth-1:0]            mgr_addr_o,
    output logic                            mgr_we_o,
    output logic [DataWidth/8-1:0]          mgr_be_o,
    output logic [DataWidth-1:0]            mgr_wdata_o,
    input  logic                            mgr_rvalid_i,
    input  logic [DataWidth-1:0]            mgr_rdata_i,
    input  logic                            mgr_err_i
);

    localparam int unsigned BeWidth  = DataWidth / 8;
    localparam int unsigned IdxWidth = $clog2(NumReq);
    localparam int unsigned PtrWidth = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
    localparam int unsigned CntWidth = $clog2(MaxTrans + 1);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    lock_state_e         lock_state;
    logic [IdxWidth-1:0] lock_idx;
    logic [IdxWidth-1:0] arb_idx;
    logic [IdxWidth-1:0] sel;
    logic                sel_req;
    logic                handshake;
    logic                fifo_full;
    logic                pop;

    logic [IdxWidth-1:0] id_fifo [MaxTrans];
    logic [PtrWidth-1:0] wr_ptr;
    logic [PtrWidth-1:0] rd_ptr;
    logic [CntWidth-1:0] count;
    logic [IdxWidth-1:0] head_id;

    // ---------------------------------------------------------------
    // Arbitration
    // ---------------------------------------------------------------
`ifdef OBI_RR_ARBITER_FIXED_PRIO_EN
    // Scan downwards so the lowest requesting index is the last write.
    always_comb begin
        arb_idx = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (sbr_req_i[i]) arb_idx = IdxWidth'(i);
        end
    end
`else
    logic [IdxWidth-1:0] rr_ptr;
    logic [IdxWidth-1:0] cand_idx;
    logic                found;

    // Circular search starting at rr_ptr; first requester found wins.
    always_comb begin
        arb_idx  = rr_ptr;
        cand_idx = '0;
        found    = 1'b0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            cand_idx = IdxWidth'((int'(rr_ptr) + k) % NumReq);
            if (!found && sbr_req_i[cand_idx]) begin
                arb_idx = cand_idx;
                found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr <= '0;
        end else if (handshake) begin
            rr_ptr <= (sel == IdxWidth'(NumReq - 1)) ? '0 : sel + 1'b1;
        end
    end
`endif

    assign sel       = (lock_state == LOCKED) ? lock_idx : arb_idx;
    assign fifo_full = (count == CntWidth'(MaxTrans));
    // Outputs are held at 0 while reset is asserted, even with requests present.
    assign sel_req   = rst_ni & sbr_req_i[sel];
    assign mgr_req_o = sel_req & ~fifo_full;
    assign handshake = mgr_req_o & mgr_gnt_i;

    assign mgr_addr_o  = sel_req ? sbr_addr_i[sel*AddrWidth +: AddrWidth] : '0;
    assign mgr_we_o    = sel_req ? sbr_we_i[sel] : 1'b0;
    assign mgr_be_o    = sel_req ? sbr_be_i[sel*BeWidth +: BeWidth] : '0;
    assign mgr_wdata_o = sel_req ? sbr_wdata_i[sel*DataWidth +: DataWidth] : '0;

    always_comb begin
        sbr_gnt_o      = '0;
        sbr_gnt_o[sel] = handshake;
    end

    // ---------------------------------------------------------------
    // Lock FSM: keeps the selection stable from req to gnt. Full FIFO
    // drops mgr_req_o but leaves the lock in place.
    // ---------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_state <= UNLOCKED;
            lock_idx   <= '0;
        end else begin
            case (lock_state)
                UNLOCKED: begin
                    if (mgr_req_o && !mgr_gnt_i) begin
                        lock_state <= LOCKED;
                        lock_idx   <= sel;
                    end
                end
                LOCKED: begin
                    if (handshake || !sbr_req_i[lock_idx]) lock_state <= UNLOCKED;
                end
                default: lock_state <= UNLOCKED;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // In-order ID FIFO
    // ---------------------------------------------------------------
    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(MaxTrans - 1)) ? '0 : p + 1'b1;
    endfunction

    // Responses with nothing outstanding are dropped.
    assign pop     = mgr_rvalid_i & (count != '0);
    assign head_id = id_fifo[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < MaxTrans; i++) id_fifo[i] <= '0;
        end else begin
            if (handshake) begin
                id_fifo[wr_ptr] <= sel;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({handshake, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        sbr_rvalid_o          = '0;
        sbr_rvalid_o[head_id] = pop;
    end

    assign sbr_err_o   = pop & mgr_err_i;
    assign sbr_rdata_o = mgr_rdata_i;

`ifndef SYNTHESIS
    a_locked_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (lock_state == LOCKED) |-> sbr_req_i[lock_idx])
        else $warning("obi_rr_arbiter: locked requester dropped its request");
    a_rvalid_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
        mgr_rvalid_i |-> (count != '0))
        else $warning("obi_rr_arbiter: response with no outstanding transaction");
`endif

endmodule

// File: tb/tb_obi_rr_arbiter.sv
module tb_obi_rr_arbiter;
  localparam int NR = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  logic [NR-1:0]      sbr_req_i, sbr_gnt_o, sbr_we_i, sbr_rvalid_o;
  logic [NR*AW-1:0]   sbr_addr_i;
  logic [NR*DW/8-1:0] sbr_be_i;
  logic [NR*DW-1:0]   sbr_wdata_i;
  logic [DW-1:0]      sbr_rdata_o, mgr_wdata_o, mgr_rdata_i;
  logic               sbr_err_o, mgr_req_o, mgr_gnt_i, mgr_we_o;
  logic [AW-1:0]      mgr_addr_o;
  logic [DW/8-1:0]    mgr_be_o;
  logic               mgr_rvalid_i, mgr_err_i;

  obi_rr_arbiter #(.NumReq(NR), .AddrWidth(AW), .DataWidth(DW), .MaxTrans(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .sbr_req_i(sbr_req_i), .sbr_gnt_o(sbr_gnt_o), .sbr_addr_i(sbr_addr_i),
    .sbr_we_i(sbr_we_i), .sbr_be_i(sbr_be_i), .sbr_wdata_i(sbr_wdata_i),
    .sbr_rvalid_o(sbr_rvalid_o), .sbr_rdata_o(sbr_rdata_o), .sbr_err_o(sbr_err_o),
    .mgr_req_o(mgr_req_o), .mgr_gnt_i(mgr_gnt_i), .mgr_addr_o(mgr_addr_o),
    .mgr_we_o(mgr_we_o), .mgr_be_o(mgr_be_o), .mgr_wdata_o(mgr_wdata_o),
    .mgr_rvalid_i(mgr_rvalid_i), .mgr_rdata_i(mgr_rdata_i), .mgr_err_i(mgr_err_i)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int i);
    return 32'hA000_0000 + 32'(i) * 32'h10;
  endfunction

  function automatic logic [NR-1:0] onehot(input int i);
    return NR'(1 << i);
  endfunction

  task automatic check_resp(input string tag);
    logic [1:0] id;
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: response with empty expected queue", tag);
    end else begin
      id = exp_q.pop_front();
      check(tag, 64'(sbr_rvalid_o), 64'(onehot(int'(id))));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk_i); #1;
  endtask

  task automatic drive(input logic [NR-1:0] req, input logic gnt, input logic rv, input logic err);
    sbr_req_i = req; mgr_gnt_i = gnt; mgr_rvalid_i = rv; mgr_err_i = err;
  endtask

  int fair_exp [6]  = '{0, 1, 0, 1, 0, 1};
  int wrap_gnt [10] = '{1, 2, 0, 1, 2, 0, 1, 2, 0, 1};
  int wrap_ptr [10] = '{2, 0, 1, 2, 0, 1, 2, 0, 1, 2};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NR; i++) begin
      sbr_addr_i[i*AW +: AW]    = addr_of(i);
      sbr_be_i[i*4 +: 4]        = 4'(1 << i);
      sbr_wdata_i[i*DW +: DW]   = 32'hD000_0000 + 32'(i);
    end
    sbr_we_i    = 3'b010;
    mgr_rdata_i = 32'h1234_5678;
    rst_ni      = 1'b0;
    drive(3'b001, 1'b1, 1'b1, 1'b1);

    // ---- reset: outputs 0 during and after reset ----
    #3;
    check("rst_mgr_req", 64'(mgr_req_o), 0);
    check("rst_gnt", 64'(sbr_gnt_o), 0);
    check("rst_addr", 64'(mgr_addr_o), 0);
    check("rst_rvalid", 64'(sbr_rvalid_o), 0);
    check("rst_err", 64'(sbr_err_o), 0);
    check("rst_rdata_follow", 64'(sbr_rdata_o), 64'h1234_5678);
    cyc(); cyc();
    drive(3'b000, 1'b0, 1'b0, 1'b0);
    rst_ni = 1'b1;
    #1;
    check("rel_mgr_req", 64'(mgr_req_o), 0);
    check("rel_count", 64'(dut.count), 0);
    check("rel_lock", 64'(dut.lock_state), 0);

`ifdef OBI_RR_ARBITER_FIXED_PRIO_EN
    // ---- fixed priority: requester 0 always wins ----
    for (int c = 0; c < 4; c++) begin
      cyc(); drive(3'b011, 1'b1, c > 0, 1'b0); #1;
      check("fix_gnt", 64'(sbr_gnt_o), 64'b001);
      if (c > 0) check_resp("fix_rvalid");
      exp_q.push_back(2'd0);
    end
    cyc(); drive(3'b000, 1'b0, 1'b1, 1'b0); #1;
    check_resp("fix_drain");
`else
    check("rel_rr_ptr", 64'(dut.rr_ptr), 0);

    // ---- fairness: req0 and req1 held, 1-cycle responses ----
    for (int c = 0; c < 6; c++) begin
      cyc(); drive(3'b011, 1'b1, c > 0, 1'b0); #1;
      check("fair_gnt", 64'(sbr_gnt_o), 64'(onehot(fair_exp[c])));
      check("fair_addr", 64'(mgr_addr_o), 64'(addr_of(fair_exp[c])));
      if (c > 0) check_resp("fair_rvalid");
      exp_q.push_back(2'(fair_exp[c]));
    end
    cyc(); check("fair_count", 64'(dut.count), 1);
    drive(3'b000, 1'b0, 1'b1, 1'b0); #1;
    check_resp("fair_drain");

    // ---- lock: req0 stalled 3 cycles, req1 arrives meanwhile ----
    cyc(); drive(3'b001, 1'b0, 1'b0, 1'b0); #1;
    check("lock_req", 64'(mgr_req_o), 1);
    check("lock_addr_c1", 64'(mgr_addr_o), 64'(addr_of(0)));
    check("lock_nognt", 64'(sbr_gnt_o), 0);
    for (int c = 0; c < 2; c++) begin
      cyc(); check("lock_state", 64'(dut.lock_state), 1);
      drive(3'b011, 1'b0, 1'b0, 1'b0); #1;
      check("lock_addr_hold", 64'(mgr_addr_o), 64'(addr_of(0)));
      check("lock_be_hold", 64'(mgr_be_o), 64'h1);
    end
    cyc(); drive(3'b011, 1'b1, 1'b0, 1'b0); #1;
    check("lock_gnt0", 64'(sbr_gnt_o), 64'b001);
    exp_q.push_back(2'd0);
    cyc(); drive(3'b010, 1'b1, 1'b0, 1'b0); #1;
    check("lock_gnt1", 64'(sbr_gnt_o), 64'b010);
    check("lock_addr1", 64'(mgr_addr_o), 64'(addr_of(1)));
    check("lock_we1", 64'(mgr_we_o), 1);
    check("lock_be1", 64'(mgr_be_o), 64'h2);
    check("lock_wdata1", 64'(mgr_wdata_o), 64'hD000_0001);
    exp_q.push_back(2'd1);

    // ---- full: two outstanding, third request held off ----
    cyc(); check("full_count", 64'(dut.count), 2);
    drive(3'b011, 1'b1, 1'b0, 1'b0); #1;
    check("full_req", 64'(mgr_req_o), 0);
    check("full_gnt", 64'(sbr_gnt_o), 0);
    cyc(); drive(3'b011, 1'b1, 1'b1, 1'b0); #1;
    check_resp("full_pop");
    check("full_pop_req", 64'(mgr_req_o), 0);
    cyc(); drive(3'b011, 1'b1, 1'b0, 1'b0); #1;
    check("full_rearm_req", 64'(mgr_req_o), 1);
    check("full_rearm_gnt", 64'(sbr_gnt_o), 64'b001);
    exp_q.push_back(2'd0);
    cyc(); drive(3'b000, 1'b0, 1'b1, 1'b0); #1; check_resp("full_drain_a");
    cyc(); drive(3'b000, 1'b0, 1'b1, 1'b0); #1; check_resp("full_drain_b");
    cyc(); drive(3'b000, 1'b0, 1'b0, 1'b0);
    check("full_end_count", 64'(dut.count), 0);
    check("full_end_ptr", 64'(dut.rr_ptr), 1);

    // ---- push/pop same cycle with rr_ptr wrap, three requesters ----
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (c > 0) begin
        check("wrap_count", 64'(dut.count), 1);
        check("wrap_ptr", 64'(dut.rr_ptr), 64'(wrap_ptr[c-1]));
      end
      drive(3'b111, 1'b1, c > 0, 1'b0); #1;
      check("wrap_gnt", 64'(sbr_gnt_o), 64'(onehot(wrap_gnt[c])));
      if (c > 0) check_resp("wrap_rvalid");
      exp_q.push_back(2'(wrap_gnt[c]));
    end
    cyc(); check("wrap_ptr_last", 64'(dut.rr_ptr), 64'(wrap_ptr[9]));
    drive(3'b000, 1'b0, 1'b1, 1'b0); #1;
    check_resp("wrap_drain");

    // ---- error response, then spurious response ----
    cyc(); drive(3'b010, 1'b1, 1'b0, 1'b0); #1;
    check("err_gnt", 64'(sbr_gnt_o), 64'b010);
    exp_q.push_back(2'd1);
    cyc(); mgr_rdata_i = 32'hCAFE_F00D; drive(3'b000, 1'b0, 1'b1, 1'b1); #1;
    check_resp("err_rvalid");
    check("err_flag", 64'(sbr_err_o), 1);
    check("err_rdata", 64'(sbr_rdata_o), 64'hCAFE_F00D);
    cyc(); drive(3'b000, 1'b0, 1'b1, 1'b1); #1;
    check("spur_rvalid", 64'(sbr_rvalid_o), 0);
    check("spur_err", 64'(sbr_err_o), 0);
    cyc(); drive(3'b000, 1'b0, 1'b0, 1'b0);
    check("spur_count", 64'(dut.count), 0);

    // ---- reset with one transaction outstanding ----
    drive(3'b001, 1'b1, 1'b0, 1'b0); #1;
    check("rst2_gnt", 64'(sbr_gnt_o), 64'b001);
    cyc(); check("rst2_count_pre", 64'(dut.count), 1);
    drive(3'b001, 1'b1, 1'b1, 1'b0);
    rst_ni = 1'b0;
    #1;
    exp_q.delete();
    check("rst2_count", 64'(dut.count), 0);
    check("rst2_mgr_req", 64'(mgr_req_o), 0);
    check("rst2_gnt_low", 64'(sbr_gnt_o), 0);
    check("rst2_rvalid", 64'(sbr_rvalid_o), 0);
    check("rst2_addr", 64'(mgr_addr_o), 0);
    cyc(); drive(3'b000, 1'b0, 1'b0, 1'b0);
    rst_ni = 1'b1;
    #1;
    check("rst2_ptr", 64'(dut.rr_ptr), 0);
    cyc(); drive(3'b000, 1'b0, 1'b1, 1'b0); #1;
    check("late_rvalid", 64'(sbr_rvalid_o), 0);
    cyc(); drive(3'b101, 1'b1, 1'b0, 1'b0); #1;
    check("post_gnt_a", 64'(sbr_gnt_o), 64'b001);
    exp_q.push_back(2'd0);
    cyc(); drive(3'b101, 1'b1, 1'b0, 1'b0); #1;
    check("post_gnt_b", 64'(sbr_gnt_o), 64'b100);
    exp_q.push_back(2'd2);
    cyc(); drive(3'b000, 1'b0, 1'b1, 1'b0); #1; check_resp("post_drain_a");
    cyc(); drive(3'b000, 1'b0, 1'b1, 1'b0); #1; check_resp("post_drain_b");
`endif

    cyc(); drive(3'b000, 1'b0, 1'b0, 1'b0);
    check("end_count", 64'(dut.count), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/obi_rr_arbiter.md
Name: obi_rr_arbiter

Overview:
- N-to-1 OBI arbiter. Shares one OBI subordinate port, e.g. the dmem SRAM, between several managers such as core data, debug SBA and a future DMA.
- Round-robin grant.
- Address-phase lock until grant.
- In-order ID FIFO routes responses back to the issuing requester.
- Sits between the crossbar manager port and the shared memory, or in front of any single-ported peripheral.

Parameters:
- NumReq, 2, number of requesters; must be >= 2.
- AddrWidth, 32, address width.
- DataWidth, 32, data width; byte enable width is DataWidth/8.
- MaxTrans, 2, maximum accepted-but-unanswered transactions; must be >= 1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- sbr_req_i  in  NumReq  per-requester request
- sbr_gnt_o  out  NumReq  per-requester grant
- sbr_addr_i  in  NumReq*AddrWidth  packed addresses; requester i occupies slice i
- sbr_we_i  in  NumReq  write enable
- sbr_be_i  in  NumReq*DataWidth/8  byte enables
- sbr_wdata_i  in  NumReq*DataWidth  write data
- sbr_rvalid_o  out  NumReq  per-requester response valid
- sbr_rdata_o  out  DataWidth  response data, broadcast to all requesters
- sbr_err_o  out  1  response error, qualified by sbr_rvalid_o
- mgr_req_o  out  1  request to the shared subordinate
- mgr_gnt_i  in  1  grant from the subordinate
- mgr_addr_o  out  AddrWidth  muxed address
- mgr_we_o  out  1  muxed write enable
- mgr_be_o  out  DataWidth/8  muxed byte enables
- mgr_wdata_o  out  DataWidth  muxed write data
- mgr_rvalid_i  in  1  response valid from the subordinate
- mgr_rdata_i  in  DataWidth  response data from the subordinate
- mgr_err_i  in  1  response error from the subordinate

Behaviour:
- Reset (asynchronous, rst_ni low):
  - rr_ptr=0, lock state=UNLOCKED, FIFO empty (count=0, rd/wr pointers=0).
  - All outputs 0 while rst_ni low and at release; sbr_rdata_o follows mgr_rdata_i.
- Selection (combinational):
  - In UNLOCKED: sel = first i with sbr_req_i[i]=1, searching circularly from rr_ptr.
  - In LOCKED: sel = lock_idx.
- Address phase:
  - mgr_req_o = sbr_req_i[sel] & !fifo_full.
  - mgr_addr_o, mgr_we_o, mgr_be_o and mgr_wdata_o = requester sel's fields; 0 when no request.
  - sbr_gnt_o[sel] = mgr_req_o & mgr_gnt_i; all other bits 0.
  - Zero added latency: the grant is combinational from mgr_gnt_i.
- Lock FSM, states UNLOCKED and LOCKED:
  - UNLOCKED -> LOCKED when mgr_req_o=1 and mgr_gnt_i=0; lock_idx<=sel.
  - LOCKED -> UNLOCKED on handshake (mgr_req_o & mgr_gnt_i), or if sbr_req_i[lock_idx] drops.
  - A dropped request is an OBI violation; the arbiter tolerates it and flags it via assertion only.
  - Purpose: address-phase signals stay stable from req to gnt, per the OBI rule.
- On handshake:
  - Push sel into the ID FIFO (MaxTrans entries, $clog2(NumReq) bits wide).
  - rr_ptr <= (sel+1) mod NumReq. Wrap: sel=NumReq-1 gives rr_ptr=0.
- Response phase:
  - mgr_rvalid_i pops the FIFO head.
  - sbr_rvalid_o[head]=1 in the same cycle; sbr_err_o=mgr_err_i.
  - Response latency is 0 cycles added.
- Full boundary:
  - count==MaxTrans forces mgr_req_o=0; no grant.
  - A pop in the same cycle does not bypass this; mgr_req_o reasserts the next cycle.
  - While full and LOCKED, the lock is held and mgr_req_o deasserts, an intentional back-pressure exception.
- Simultaneous push and pop: count unchanged; both pointers advance; ordering preserved.
- Empty boundary: mgr_rvalid_i with count==0 is ignored (no sbr_rvalid_o, no underflow) and flagged by assertion.
- Reset mid-transaction: outstanding IDs are discarded; late responses from the subordinate are ignored per the empty rule.
- Count width: $clog2(MaxTrans+1); pointer width: $clog2(MaxTrans), minimum 1.

Optional Feature:
- Macro: OBI_RR_ARBITER_FIXED_PRIO_EN.
- Defined: fixed priority. sel = lowest-index requesting requester; rr_ptr is not implemented. The lock FSM and ID FIFO are unchanged.
- Undefined: round-robin as above.

Test Plan:
- Fairness:
  - Stimulus: NumReq=2, both requesters hold req continuously, mgr_gnt_i=1, 1-cycle responses.
  - Expected: grants alternate 0,1,0,1; each rvalid is routed to the issuing requester.
- Lock:
  - Stimulus: req0 at cycle 1, mgr_gnt_i=0 for 3 cycles; req1 raised at cycle 2.
  - Expected: mgr_addr_o stays at addr0 until the grant at cycle 4; req1 is granted next.
- Full:
  - Stimulus: MaxTrans=2, two granted transactions with no response.
  - Expected: mgr_req_o=0 on the 3rd request. After one rvalid, mgr_req_o=1 the following cycle.
- Push/pop same cycle and wrap:
  - Stimulus: NumReq=3, back-to-back traffic where grant and response coincide for 10 cycles.
  - Expected: count is constant; rr_ptr wraps 2 -> 0; response IDs are in order.
- Error, spurious response and reset:
  - Stimulus: mgr_err_i=1 on requester 1's response; a spurious mgr_rvalid_i with the FIFO empty; rst_ni pulsed low with 1 transaction outstanding.
  - Expected: sbr_err_o=1 together with sbr_rvalid_o[1]; no sbr_rvalid_o for the spurious response; after reset, count=0 and all outputs 0.
- Fixed priority (build with OBI_RR_ARBITER_FIXED_PRIO_EN):
  - Stimulus: req0 and req1 held continuously.
  - Expected: only requester 0 is granted.
